// File: rtl/dfp_sub_if.sv
`default_nettype none
// ============================================================================
// Module  : dfp_sub_if
// Brief   : Operand/result bundle for the binary64 add/sub functional unit.
// Rev     : 1.0 - initial release
// ============================================================================
interface dfp_sub_if;
    logic        sign_a;
    logic        sign_b;
    logic [10:0] exp_a;
    logic [10:0] exp_b;
    logic [51:0] mant_a;
    logic [51:0] mant_b;
    logic [63:0] res;
    logic [7:0]  flags;

    modport master (
        output sign_a, sign_b, exp_a, exp_b, mant_a, mant_b,
        input  res, flags
    );

    modport slave (
        input  sign_a, sign_b, exp_a, exp_b, mant_a, mant_b,
        output res, flags
    );
endinterface
`default_nettype wire

// File: rtl/dfp_sub_unit.sv
`default_nettype none
// ============================================================================
// Module  : dfp_sub_unit
// Brief   : IEEE-754 binary64 adder (DAZ/FTZ, round-nearest-even), output
//           registered, one result per cycle.
// Rev     : 1.0 - initial release
// ============================================================================
module dfp_sub_unit (
    input  wire logic  clk,
    input  wire logic  rst_n,
    dfp_sub_if.slave   bus
);

    localparam logic [10:0] C_EXP_MAX = 11'h7FF;
    localparam logic [63:0] C_QNAN    = 64'h7FF8_0000_0000_0000;

    logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [62:0] w_mag_a, w_mag_b;
    logic        w_a_big;
    logic [52:0] w_sig_a, w_sig_b, w_sig_l, w_sig_s;
    logic [10:0] w_exp_l, w_exp_s, w_exp_diff;
    logic        w_sign_l;
    logic [111:0] w_shifted;
    logic [55:0] w_small_ext, w_large_ext;
    logic        w_eff_sub;
    logic [56:0] w_sum;
    logic [5:0]  w_lzc;
    logic        w_lzc_found;
    logic [55:0] w_norm;
    logic [12:0] w_exp_norm, w_exp_fin;
    logic        w_inexact, w_round_up;
    logic [53:0] w_rounded;
    logic [51:0] w_frac;
    logic        w_zero_sign;
    logic [63:0] w_res_nxt;
    logic [7:0]  w_flags_nxt;
    logic [63:0] r_res;
    logic [7:0]  r_flags;

    // Classification; exponent 0 is a signed zero regardless of fraction.
    assign w_a_zero = (bus.exp_a == 11'd0);
    assign w_b_zero = (bus.exp_b == 11'd0);
    assign w_a_inf  = (bus.exp_a == C_EXP_MAX) && (bus.mant_a == 52'd0);
    assign w_b_inf  = (bus.exp_b == C_EXP_MAX) && (bus.mant_b == 52'd0);
    assign w_a_nan  = (bus.exp_a == C_EXP_MAX) && (bus.mant_a != 52'd0);
    assign w_b_nan  = (bus.exp_b == C_EXP_MAX) && (bus.mant_b != 52'd0);

    assign w_mag_a  = w_a_zero ? 63'd0 : {bus.exp_a, bus.mant_a};
    assign w_mag_b  = w_b_zero ? 63'd0 : {bus.exp_b, bus.mant_b};
    assign w_a_big  = (w_mag_a >= w_mag_b);
    assign w_sig_a  = w_a_zero ? 53'd0 : {1'b1, bus.mant_a};
    assign w_sig_b  = w_b_zero ? 53'd0 : {1'b1, bus.mant_b};

    assign w_sig_l    = w_a_big ? w_sig_a : w_sig_b;
    assign w_sig_s    = w_a_big ? w_sig_b : w_sig_a;
    assign w_exp_l    = w_a_big ? bus.exp_a : bus.exp_b;
    assign w_exp_s    = w_a_big ? bus.exp_b : bus.exp_a;
    assign w_sign_l   = w_a_big ? bus.sign_a : bus.sign_b;
    assign w_exp_diff = w_exp_l - w_exp_s;

    // Layout of the 56-bit working significand: [55:3] value, [2] G, [1] R, [0] S.
    assign w_shifted   = {w_sig_s, 3'b000, 56'd0} >> w_exp_diff;
    assign w_small_ext = (w_exp_diff >= 11'd56) ? {55'd0, |w_sig_s}
                       : {w_shifted[111:57], w_shifted[56] | (|w_shifted[55:0])};
    assign w_large_ext = {w_sig_l, 3'b000};

    assign w_eff_sub = bus.sign_a ^ bus.sign_b;
    assign w_sum     = w_eff_sub ? ({1'b0, w_large_ext} - {1'b0, w_small_ext})
                                 : ({1'b0, w_large_ext} + {1'b0, w_small_ext});

    always_comb begin
        w_lzc       = 6'd0;
        w_lzc_found = 1'b0;
        for (int i = 55; i >= 0; i--) begin
            if (!w_lzc_found && w_sum[i]) begin
                w_lzc       = 6'(55 - i);
                w_lzc_found = 1'b1;
            end
        end
    end

    // Exponents are carried in 13 bits so a negative result shows up in bit 12.
    always_comb begin
        if (w_sum[56]) begin
            w_norm     = {w_sum[56:2], w_sum[1] | w_sum[0]};
            w_exp_norm = {2'b00, w_exp_l} + 13'd1;
        end else begin
            w_norm     = w_sum[55:0] << w_lzc;
            w_exp_norm = {2'b00, w_exp_l} - {7'd0, w_lzc};
        end
    end

    assign w_inexact  = w_norm[2] | w_norm[1] | w_norm[0];
    assign w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_rounded  = {1'b0, w_norm[55:3]} + {53'd0, w_round_up};
    assign w_frac     = w_rounded[53] ? w_rounded[52:1] : w_rounded[51:0];
    assign w_exp_fin  = w_exp_norm + {12'd0, w_rounded[53]};
    assign w_zero_sign = w_a_zero & w_b_zero & bus.sign_a & bus.sign_b;

    always_comb begin
        w_res_nxt   = 64'd0;
        w_flags_nxt = 8'h00;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && w_eff_sub)) begin
            w_res_nxt   = C_QNAN;
            w_flags_nxt = 8'h50;
        end else if (w_a_inf || w_b_inf) begin
            w_res_nxt   = {(w_a_inf ? bus.sign_a : bus.sign_b), C_EXP_MAX, 52'd0};
            w_flags_nxt = {(w_a_inf ? bus.sign_a : bus.sign_b), 7'b0100000};
        end else if (w_sum == 57'd0) begin
            w_res_nxt   = {w_zero_sign, 63'd0};
            w_flags_nxt = {w_zero_sign, 7'b0000001};
        end else if (w_exp_fin[12]) begin
            w_res_nxt   = {w_sign_l, 63'd0};
            w_flags_nxt = {w_sign_l, 7'b0001101};
        end else if (w_exp_fin == 13'd0) begin
            w_res_nxt   = {w_sign_l, 63'd0};
            w_flags_nxt = {w_sign_l, 7'b0001101};
        end else if (w_exp_fin >= 13'd2047) begin
            w_res_nxt   = {w_sign_l, C_EXP_MAX, 52'd0};
            w_flags_nxt = {w_sign_l, 7'b0101010};
        end else begin
            w_res_nxt   = {w_sign_l, w_exp_fin[10:0], w_frac};
            w_flags_nxt = {w_sign_l, 3'b000, w_inexact, 3'b000};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res   <= 64'd0;
            r_flags <= 8'h00;
        end else begin
            r_res   <= w_res_nxt;
            r_flags <= w_flags_nxt;
        end
    end

    assign bus.res   = r_res;
    assign bus.flags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_dfp_sub_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_dfp_sub_unit
// Brief   : Directed-vector self-checking bench for dfp_sub_unit.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_dfp_sub_unit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    dfp_sub_if bus ();

    dfp_sub_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b);
        bus.sign_a = a[63];
        bus.exp_a  = a[62:52];
        bus.mant_a = a[51:0];
        bus.sign_b = b[63];
        bus.exp_b  = b[62:52];
        bus.mant_b = b[51:0];
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input logic [7:0] exp_flags);
        @(negedge clk);
        drive(a, b);
        @(posedge clk);
        #1;
        check_val({tag, ".res"}, bus.res, exp_res);
        check_val({tag, ".flags"}, {56'd0, bus.flags}, {56'd0, exp_flags});
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        drive(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000);
        repeat (3) @(posedge clk);
        #1;
        check_val("reset.res", bus.res, 64'd0);
        check_val("reset.flags", {56'd0, bus.flags}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("ref",      64'h4023_8000_0000_0000, 64'hBFE2_0000_0000_0000, 64'h4022_6000_0000_0000, 8'h00);
        run_op("one_one",  64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 8'h00);
        run_op("tie_even", 64'h3FF0_0000_0000_0000, 64'h3CA0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 8'h08);
        run_op("tie_up",   64'h3FF0_0000_0000_0001, 64'h3CA0_0000_0000_0000, 64'h3FF0_0000_0000_0002, 8'h08);
        run_op("cancel",   64'h4014_0000_0000_0000, 64'hC014_0000_0000_0000, 64'h0000_0000_0000_0000, 8'h01);
        run_op("neg_zero", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 8'h81);
        run_op("overflow", 64'h7FEF_FFFF_FFFF_FFFF, 64'h7FEF_FFFF_FFFF_FFFF, 64'h7FF0_0000_0000_0000, 8'h2A);
        run_op("inf_minf", 64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 8'h50);
        run_op("nan_one",  64'h7FF8_0000_0000_0001, 64'h3FF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 8'h50);
        run_op("inf_three",64'h7FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h7FF0_0000_0000_0000, 8'h20);
        run_op("three_minf",64'h4008_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 8'hA0);
        run_op("one_one_b",64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 8'h00);

        // Asynchronous reset between edges, with a live result on the outputs.
        @(negedge clk);
        drive(64'h4014_0000_0000_0000, 64'h4014_0000_0000_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst.res", bus.res, 64'd0);
        check_val("async_rst.flags", {56'd0, bus.flags}, 64'd0);
        @(posedge clk);
        #1;
        check_val("rst_hold.res", bus.res, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("underflow", 64'h0010_0000_0000_0001, 64'h8010_0000_0000_0000, 64'h0000_0000_0000_0000, 8'h0D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
